// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared FSM states and filter-group helpers for the OFM writer.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } ofm_state_e;

    function automatic int calc_no_load_filter(input int no_filter, input int systolic_size);
        return (no_filter + systolic_size - 1) / systolic_size;
    endfunction

    // Number of real filters carried by the final (possibly partial) group.
    function automatic int last_group_lanes(input int no_filter, input int systolic_size);
        return no_filter - (calc_no_load_filter(no_filter, systolic_size) - 1) * systolic_size;
    endfunction

    function automatic logic lane_enabled(input int lane, input logic last_group, input int valid_lanes);
        return !last_group || (lane < valid_lanes);
    endfunction

endpackage

// File: rtl/ofm_writer_if.sv
// rtl/ofm_writer_if.sv - OFM memory write port between the writer and the feature-map memory.
interface ofm_writer_if #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 14
);
    logic                                mem_wr_en;
    logic [ADDR_WIDTH-1:0]               mem_addr;
    logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] mem_wr_data;
    logic [SYSTOLIC_SIZE-1:0]            mem_lane_mask;
    logic                                mem_ready;

    modport master (
        output mem_wr_en, mem_addr, mem_wr_data, mem_lane_mask,
        input  mem_ready
    );

    modport slave (
        input  mem_wr_en, mem_addr, mem_wr_data, mem_lane_mask,
        output mem_ready
    );
endinterface

// File: rtl/ofm_fifo.sv
// rtl/ofm_fifo.sv - show-ahead FIFO with wrap-bit pointers; DEPTH must be a power of 2, at least 2.
module ofm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[PW-1:0]];

    // A push while full is legal only alongside a pop; the slot written is the one being read out.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[PW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/ofm_writer.sv
// rtl/ofm_writer.sv - captures systolic output vectors, applies ReLU, and streams them to OFM memory.
module ofm_writer
    import systolic_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int NO_FILTER     = 16,
    parameter int NO_TILE       = 64,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 14,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                write_out_en,
    input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] data_in,
    input  logic                                relu_en,
    ofm_writer_if.master                        mem,
    output logic                                busy,
    output logic                                overflow,
    output logic                                done
);
    localparam int NO_LOAD_FILTER = calc_no_load_filter(NO_FILTER, SYSTOLIC_SIZE);
    localparam int LAST_LANES     = last_group_lanes(NO_FILTER, SYSTOLIC_SIZE);
    localparam int DW             = SYSTOLIC_SIZE * DATA_WIDTH;
    localparam int FW             = DW + ADDR_WIDTH + SYSTOLIC_SIZE;
    localparam int ROW_W          = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam int TILE_W         = (NO_TILE > 1) ? $clog2(NO_TILE) : 1;
    localparam int GRP_W          = (NO_LOAD_FILTER > 1) ? $clog2(NO_LOAD_FILTER) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SYSTOLIC_SIZE - 1);
    localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NO_TILE - 1);
    localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(NO_LOAD_FILTER - 1);

    ofm_state_e        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [GRP_W-1:0]  group_q, group_d;
    logic              overflow_q, overflow_d;

    logic                     fifo_full, fifo_empty;
    logic                     accept_in, push, pop, last_vec;
    logic [DW-1:0]            data_proc;
    logic [SYSTOLIC_SIZE-1:0] lane_mask;
    logic [ADDR_WIDTH-1:0]    vec_addr;
    logic [FW-1:0]            fifo_wr, fifo_rd;
    logic [DW-1:0]            head_data;
    logic [ADDR_WIDTH-1:0]    head_addr;
    logic [SYSTOLIC_SIZE-1:0] head_mask;

    assign accept_in = (state_q == ST_RUN) && write_out_en;
    assign pop       = !fifo_empty && mem.mem_ready;
    assign push      = accept_in && (!fifo_full || pop);
    assign last_vec  = (group_q == GRP_LAST) && (tile_q == TILE_LAST) && (row_q == ROW_LAST);

    // Address arithmetic wraps modulo 2**ADDR_WIDTH.
    assign vec_addr = ADDR_WIDTH'(group_q) * ADDR_WIDTH'(NO_TILE * SYSTOLIC_SIZE)
                    + ADDR_WIDTH'(tile_q) * ADDR_WIDTH'(SYSTOLIC_SIZE)
                    + ADDR_WIDTH'(row_q);

    always_comb begin
        data_proc = data_in;
        lane_mask = '0;
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            if (relu_en && data_in[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
                data_proc[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
            lane_mask[i] = lane_enabled(i, group_q == GRP_LAST, LAST_LANES);
        end
    end

    assign fifo_wr = {lane_mask, vec_addr, data_proc};

    ofm_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {head_mask, head_addr, head_data} = fifo_rd;

    assign mem.mem_wr_en     = !fifo_empty;
    assign mem.mem_addr      = fifo_empty ? '0 : head_addr;
    assign mem.mem_wr_data   = fifo_empty ? '0 : head_data;
    assign mem.mem_lane_mask = fifo_empty ? '0 : head_mask;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        tile_d     = tile_q;
        group_d    = group_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    row_d      = '0;
                    tile_d     = '0;
                    group_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (accept_in && !push) begin
                    overflow_d = 1'b1;
                end
                if (push) begin
                    if (row_q == ROW_LAST) begin
                        row_d = '0;
                        if (tile_q == TILE_LAST) begin
                            tile_d  = '0;
                            group_d = (group_q == GRP_LAST) ? '0 : group_q + GRP_W'(1);
                        end else begin
                            tile_d = tile_q + TILE_W'(1);
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                    if (last_vec) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            tile_q     <= '0;
            group_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            tile_q     <= tile_d;
            group_q    <= group_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign overflow = overflow_q;
endmodule

// File: doc/ofm_writer.md
OFM_WRITER -- requirements
Module: ofm_writer

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 16, the number of array lanes (filters) per output vector.
REQ-002 SHALL have parameter NO_FILTER, default 16, the total filters; NO_LOAD_FILTER = ceil(NO_FILTER/SYSTOLIC_SIZE).
REQ-003 SHALL have parameter NO_TILE, default 64, the tiles per filter group.
REQ-004 SHALL have parameter DATA_WIDTH, default 16, the signed result width per lane.
REQ-005 SHALL have parameters ADDR_WIDTH, default 14, the OFM word address width, and FIFO_DEPTH, default 4, a power of 2.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk, input, 1, rising-edge clock.
REQ-007 SHALL have rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have the following further ports:
- start, input, 1: begin a layer.
- write_out_en, input, 1: array output vector valid this cycle.
- data_in, input, SYSTOLIC_SIZE*DATA_WIDTH: lane i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- relu_en, input, 1: clamp negative lanes to 0.
- mem_ready, input, 1: OFM memory accepts a write this cycle.
- mem_wr_en, output, 1: write request.
- mem_addr, output, ADDR_WIDTH: OFM vector address.
- mem_wr_data, output, SYSTOLIC_SIZE*DATA_WIDTH: processed vector.
- mem_lane_mask, output, SYSTOLIC_SIZE: per-lane byte-enable.
- busy, output, 1.
- overflow, output, 1: sticky dropped-vector flag.
- done, output, 1: one-cycle layer-complete pulse.

Function
REQ-009 SHALL implement an FSM with states IDLE, RUN, FLUSH and DONE.
REQ-010 SHALL move IDLE->RUN on start; start SHALL be ignored in every other state.
REQ-011 SHALL, in IDLE, ignore write_out_en, with no push and no counter change.
REQ-012 SHALL, in RUN, capture data_in each write_out_en cycle, apply ReLU per lane when relu_en=1 (signed < 0 -> 0), and push {data, addr, mask} into the FIFO.
REQ-013 SHALL compute addr = group*(NO_TILE*SYSTOLIC_SIZE) + tile*SYSTOLIC_SIZE + row, truncated to ADDR_WIDTH.
REQ-014 SHALL advance row_cnt by 1 on each accepted vector; at SYSTOLIC_SIZE-1 it SHALL wrap to 0 and increment tile_cnt.
REQ-015 SHALL wrap tile_cnt at NO_TILE-1 to 0 and increment group_cnt.
REQ-016 SHALL set the mask to all ones except in the last group, where lanes >= NO_FILTER - (NO_LOAD_FILTER-1)*SYSTOLIC_SIZE are 0.
REQ-017 SHALL move RUN->FLUSH on the cycle the last vector (group=NO_LOAD_FILTER-1, tile=NO_TILE-1, row=SYSTOLIC_SIZE-1) is pushed.
REQ-018 SHALL move FLUSH->DONE when the FIFO is empty, and DONE->IDLE unconditionally after 1 cycle; done=1 only in DONE.
REQ-019 SHALL drive the FIFO head directly: mem_wr_en = !empty; a pop occurs when mem_wr_en && mem_ready; mem_addr/mem_wr_data/mem_lane_mask SHALL hold while stalled.
REQ-020 SHALL give a 1-cycle latency: a vector pushed at edge k is presented at mem_* after edge k when the FIFO was empty.
REQ-021 SHALL accept a push when the FIFO is full only if a pop occurs in the same cycle; otherwise the vector SHALL be dropped, counters SHALL NOT advance, and overflow SHALL be set.
REQ-022 SHALL clear overflow only on rst or on an accepted start.
REQ-023 SHALL perform simultaneous push and pop when not full, leaving occupancy unchanged.
REQ-024 SHALL drive busy=1 in RUN, FLUSH and DONE.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, including mid-layer, set the state to IDLE, all counters 0, FIFO empty, mem_wr_en=0, mem_addr=0, mem_wr_data=0, mem_lane_mask=0, busy=0, overflow=0 and done=0.

Structure
REQ-026 SHALL place the FSM state encodings and the NO_LOAD_FILTER and last-group mask computation in a shared package (systolic_pkg).
REQ-027 SHALL implement the FIFO as one sub-module, ofm_fifo (parameterised width/depth, registered pointers, full/empty flags).

Verification
REQ-028 SHALL cover: start, then 16 write_out_en with mem_ready=1 -> 16 writes at addr 0..15, mask 16'hFFFF, each 1 cycle after capture.
REQ-029 SHALL cover: lane 3 = -5 with relu_en=1 -> lane 3 written as 0; with relu_en=0 -> lane 3 written as -5.
REQ-030 SHALL cover: mem_ready=0 for 6 consecutive write_out_en -> 4 stored, 2 dropped, overflow=1, and the next accepted vector gets addr 4.
REQ-031 SHALL cover: NO_FILTER=20, full layer of 2*64*16 vectors -> group 1 addr starts at 1024, mask 16'h000F, done pulses once after the FIFO drains.
REQ-032 SHALL cover: rst asserted at row 7 of tile 3 -> all outputs reach reset values the next cycle, and a new start restarts at addr 0.
REQ-033 SHALL cover: start asserted during RUN -> ignored, counters continue, overflow not cleared.
